// File: rtl/vga_fb_arbiter_if.sv
// Writer-side handshake into the framebuffer arbiter: the master offers one pixel write,
// the arbiter takes it with wr_ready in any cycle not claimed by display or clear.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) ();
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer RAM arbiter: visible-pixel reads always win, leftover cycles go
// to the external writer or to the clear engine that fills the whole buffer.
module vga_fb_arbiter #(
    parameter int H_START     = 145,
    parameter int V_START     = 36,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SCALE_SHIFT = 2,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pixel_tick,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    vga_fb_arbiter_if.slave   wr,
    input  logic              clear_req,
    input  logic [DATA_W-1:0] clear_color,
    output logic              busy,
    output logic              clear_done,
    output logic              wr_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_color,
    output logic              pix_valid
);
    localparam int FB_W = H_ACTIVE >> SCALE_SHIFT;
    localparam int FB_H = V_ACTIVE >> SCALE_SHIFT;
    localparam int FB_N = FB_W * FB_H;

    localparam logic [9:0]        X_LO      = 10'(H_START);
    localparam logic [9:0]        X_HI      = 10'(H_START + H_ACTIVE);
    localparam logic [9:0]        Y_LO      = 10'(V_START);
    localparam logic [9:0]        Y_HI      = 10'(V_START + V_ACTIVE);
    localparam logic [ADDR_W-1:0] FB_W_A    = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0] FB_N_A    = ADDR_W'(FB_N);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_N - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] cnt, cnt_next;
    logic [DATA_W-1:0] fill, fill_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] wdata_next;
    logic              we_next, done_next, err_next;

    logic              in_win, disp_slot, wr_accept;
    logic [9:0]        x_off, y_off;
    logic [ADDR_W-1:0] disp_addr;
    logic              slot_d1, slot_d2;

    assign in_win    = (pixel_x >= X_LO) && (pixel_x < X_HI) &&
                       (pixel_y >= Y_LO) && (pixel_y < Y_HI);
    assign disp_slot = pixel_tick && in_win;
    assign x_off     = pixel_x - X_LO;
    assign y_off     = pixel_y - Y_LO;
    assign disp_addr = ADDR_W'(y_off >> SCALE_SHIFT) * FB_W_A + ADDR_W'(x_off >> SCALE_SHIFT);

    // Clear requests outrank the writer, and a pending display read outranks both.
    assign wr.wr_ready = !reset && (state == IDLE) && !clear_req && !disp_slot;
    assign wr_accept   = wr.wr_valid && wr.wr_ready;
    assign busy        = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        fill_next  = fill;
        addr_next  = mem_addr;
        wdata_next = mem_wdata;
        we_next    = 1'b0;
        done_next  = 1'b0;
        err_next   = wr_err;

        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                    fill_next  = clear_color;
                end else if (wr_accept) begin
                    if (wr.wr_addr < FB_N_A) begin
                        addr_next  = wr.wr_addr;
                        wdata_next = wr.wr_data;
                        we_next    = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (!disp_slot) begin
                    addr_next  = cnt;
                    wdata_next = fill;
                    we_next    = 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (disp_slot) addr_next = disp_addr;
    end

    // NOTE: registers take non-blocking assignments so every flop samples the values
    // from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            fill       <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            clear_done <= 1'b0;
            wr_err     <= 1'b0;
            slot_d1    <= 1'b0;
            slot_d2    <= 1'b0;
            pix_color  <= '0;
            pix_valid  <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            fill       <= fill_next;
            mem_addr   <= addr_next;
            mem_we     <= we_next;
            mem_wdata  <= wdata_next;
            clear_done <= done_next;
            wr_err     <= err_next;
            // Slot flag rides alongside the RAM read so pix_color lands three cycles after the tick.
            slot_d1    <= disp_slot;
            slot_d2    <= slot_d1;
            pix_valid  <= slot_d2;
            pix_color  <= slot_d2 ? mem_rdata : '0;
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: a behavioural model queues expected RAM writes,
// display reads and pixel outputs; a negedge monitor pops and compares them.
module tb_vga_fb_arbiter;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int FB_N   = 19200;

    logic        clk = 1'b0;
    logic        reset;
    logic        pixel_tick;
    logic [9:0]  pixel_x, pixel_y;
    logic        clear_req;
    logic [7:0]  clear_color;
    logic        busy, clear_done, wr_err, mem_we, pix_valid;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata, pix_color;

    always #5 clk = ~clk;

    vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr_bus ();

    vga_fb_arbiter dut (
        .clk(clk), .reset(reset),
        .pixel_tick(pixel_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .wr(wr_bus),
        .clear_req(clear_req), .clear_color(clear_color),
        .busy(busy), .clear_done(clear_done), .wr_err(wr_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pix_color(pix_color), .pix_valid(pix_valid)
    );

    // Synchronous single-port RAM with one cycle of read latency.
    logic [7:0] ram [0:32767];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct { int due; logic [14:0] addr; logic [7:0] data; bit last; } wr_exp_t;
    typedef struct { int due; logic [14:0] addr; } rd_exp_t;
    typedef struct { int due; logic valid; logic [7:0] color; bit chk_color; } pix_exp_t;

    wr_exp_t  wr_q[$];
    rd_exp_t  rd_q[$];
    pix_exp_t pix_q[$];

    logic [7:0] gold  [0:FB_N-1];
    bit         known [0:FB_N-1];

    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic exp_ready = 1'b0, exp_busy = 1'b0, exp_err = 1'b0;

    bit         m_busy = 1'b0, m_err = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_color = 8'h00;

    logic [14:0] wa;
    logic [7:0]  wd;
    logic        acc;
    int          guard;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drive_cycle(input logic tick, input logic [9:0] x, input logic [9:0] y,
                               input logic wv, input logic [14:0] a_in, input logic [7:0] d_in,
                               input logic creq, input logic [7:0] ccol, output logic accepted);
        bit       slot;
        int       a;
        pix_exp_t p;
        reset          = 1'b0;
        pixel_tick     = tick;
        pixel_x        = x;
        pixel_y        = y;
        wr_bus.wr_valid = wv;
        wr_bus.wr_addr  = a_in;
        wr_bus.wr_data  = d_in;
        clear_req      = creq;
        clear_color    = ccol;

        slot = tick && int'(x) >= 145 && int'(x) < 785 && int'(y) >= 36 && int'(y) < 516;
        exp_busy  = m_busy;
        exp_err   = m_err;
        exp_ready = !m_busy && !creq && !slot;
        accepted  = wv && exp_ready;

        p.due = cyc + 3; p.valid = slot; p.color = 8'h00; p.chk_color = 1'b1;
        if (slot) begin
            a = ((int'(y) - 36) / 4) * 160 + (int'(x) - 145) / 4;
            rd_q.push_back('{cyc + 1, 15'(a)});
            p.color     = gold[a];
            p.chk_color = known[a];
        end
        pix_q.push_back(p);

        if (m_busy) begin
            if (!slot) begin
                wr_q.push_back('{cyc + 1, 15'(m_cnt), m_color, m_cnt == FB_N - 1});
                gold[m_cnt]  = m_color;
                known[m_cnt] = 1'b1;
                if (m_cnt == FB_N - 1) m_busy = 1'b0;
                else                   m_cnt++;
            end
        end else if (creq) begin
            m_busy  = 1'b1;
            m_cnt   = 0;
            m_color = ccol;
        end else if (accepted) begin
            if (int'(a_in) < FB_N) begin
                wr_q.push_back('{cyc + 1, a_in, d_in, 1'b0});
                gold[a_in]  = d_in;
                known[a_in] = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
        next_cycle();
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            reset           = 1'b1;
            pixel_tick      = 1'($urandom);
            pixel_x         = 10'($urandom_range(0, 799));
            pixel_y         = 10'($urandom_range(0, 524));
            clear_req       = 1'($urandom);
            clear_color     = 8'($urandom);
            wr_bus.wr_valid = 1'($urandom);
            wr_bus.wr_addr  = 15'($urandom);
            wr_bus.wr_data  = 8'($urandom);
            exp_ready = 1'b0;
            if (i == 0) begin
                exp_busy = m_busy;
                exp_err  = m_err;
                foreach (pix_q[k]) begin
                    if (pix_q[k].due > cyc) begin
                        pix_q[k].valid     = 1'b0;
                        pix_q[k].color     = 8'h00;
                        pix_q[k].chk_color = 1'b1;
                    end
                end
            end else begin
                exp_busy = 1'b0;
                exp_err  = 1'b0;
                mon_en   = 1'b1;
                check("rst_mem", {mem_addr, mem_we, mem_wdata}, 32'h0);
                check("rst_out", {pix_color, pix_valid, busy, clear_done, wr_err}, 32'h0);
            end
            #1;
            check("rst_ready", wr_bus.wr_ready, 1'b0);
            pix_q.push_back('{cyc + 3, 1'b0, 8'h00, 1'b1});
            m_busy = 1'b0;
            m_err  = 1'b0;
            m_cnt  = 0;
            next_cycle();
        end
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++)
            drive_cycle(1'b0, 10'd0, 10'd0, 1'b0, 15'd0, 8'd0, 1'b0, 8'd0, a);
    endtask

    task automatic sweep(input int n);
        logic a;
        for (int i = 0; i < n; i++) begin
            drive_cycle(1'b1, 10'($urandom_range(145, 784)), 10'($urandom_range(36, 515)),
                        1'b0, 15'd0, 8'd0, 1'b0, 8'd0, a);
            drive_cycle(1'b0, 10'd0, 10'd0, 1'b0, 15'd0, 8'd0, 1'b0, 8'd0, a);
        end
        idle(4);
    endtask

    wr_exp_t  mw;
    rd_exp_t  mr;
    pix_exp_t mp;
    bit       mon_done;

    always @(negedge clk) begin
        if (mon_en) begin
            mon_done = 1'b0;
            check("wr_ready", wr_bus.wr_ready, exp_ready);
            check("busy", busy, exp_busy);
            check("wr_err", wr_err, exp_err);
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    check("unexp_we", mem_we, 1'b0);
                end else begin
                    mw = wr_q.pop_front();
                    check("we_cycle", cyc, mw.due);
                    check("we_addr", mem_addr, mw.addr);
                    check("we_data", mem_wdata, mw.data);
                    mon_done = mw.last;
                end
            end
            check("clear_done", clear_done, mon_done);
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                mr = rd_q.pop_front();
                check("rd_addr", mem_addr, mr.addr);
                check("rd_we", mem_we, 1'b0);
            end
            if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
                mp = pix_q.pop_front();
                check("pix_valid", pix_valid, mp.valid);
                if (mp.chk_color) check("pix_color", pix_color, mp.color);
            end
        end
    end

    int bx [8] = '{144, 145, 784, 785, 200, 200, 200, 200};
    int by [8] = '{100, 100, 100, 100,  35,  36, 515, 516};

    initial begin
        reset = 1'b1;
        pixel_tick = 1'b0; pixel_x = '0; pixel_y = '0;
        clear_req = 1'b0; clear_color = '0;
        wr_bus.wr_valid = 1'b0; wr_bus.wr_addr = '0; wr_bus.wr_data = '0;

        // Reset held two cycles with random inputs.
        do_reset(2);

        // Preload fb[161]=0xA5, then read it back through a tick at (149,40).
        drive_cycle(1'b0, 10'd0, 10'd0, 1'b1, 15'd161, 8'hA5, 1'b0, 8'h00, acc);
        idle(2);
        drive_cycle(1'b1, 10'd149, 10'd40, 1'b0, 15'd0, 8'd0, 1'b0, 8'd0, acc);
        idle(4);

        // Ticks outside the window, then window edges.
        drive_cycle(1'b1, 10'd100, 10'd20, 1'b0, 15'd0, 8'd0, 1'b0, 8'd0, acc);
        idle(4);
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, 10'(bx[i]), 10'(by[i]), 1'b0, 15'd0, 8'd0, 1'b0, 8'd0, acc);
            idle(1);
        end
        idle(4);

        // Writer held valid against alternating in-window ticks.
        wa = 15'd5000;
        wd = 8'h40;
        for (int i = 0; i < 40; i++) begin
            drive_cycle(i % 2 == 0, 10'(145 + 4 * i), 10'd100, 1'b1, wa, wd, 1'b0, 8'h00, acc);
            if (acc) begin
                wa++;
                wd++;
            end
        end
        idle(4);

        // Out-of-range write sets the sticky error; the last legal address still writes.
        drive_cycle(1'b0, 10'd0, 10'd0, 1'b1, 15'd19200, 8'hEE, 1'b0, 8'h00, acc);
        idle(2);
        drive_cycle(1'b0, 10'd0, 10'd0, 1'b1, 15'd19199, 8'h77, 1'b0, 8'h00, acc);
        idle(3);

        // Full clear in blanking, clear and writer requested together, a stray clear_req mid-way.
        drive_cycle(1'b0, 10'd10, 10'd10, 1'b1, 15'd3, 8'h99, 1'b1, 8'h1C, acc);
        guard = 0;
        while (m_busy && guard < 25000) begin
            drive_cycle(guard % 2 == 0, 10'd10, 10'd10, 1'b1, 15'd3, 8'h99, guard == 50, 8'h55, acc);
            guard++;
        end
        idle(3);
        sweep(20);

        // Reset at clear count 100, then a full clear that stalls behind display reads.
        drive_cycle(1'b0, 10'd10, 10'd10, 1'b0, 15'd0, 8'd0, 1'b1, 8'h3E, acc);
        guard = 0;
        while (m_cnt < 100 && guard < 1000) begin
            idle(1);
            guard++;
        end
        do_reset(1);
        idle(2);
        drive_cycle(1'b0, 10'd10, 10'd10, 1'b0, 15'd0, 8'd0, 1'b1, 8'h3E, acc);
        guard = 0;
        while (m_busy && guard < 40000) begin
            drive_cycle(guard < 300 && guard % 2 == 0, 10'(145 + 4 * (guard % 160)), 10'd36,
                        1'b0, 15'd0, 8'd0, 1'b0, 8'd0, acc);
            guard++;
        end
        idle(3);
        sweep(20);

        check("wr_q_drained", wr_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
